// File: rtl/mac_sequencer.sv
// Multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL sequencer: 8 multiplier bits per
// cycle with early termination, optional accumulate, N/Z flags on the result.
//
// state | meaning
// IDLE  | ready for a command
// ITER  | consuming rs one byte per cycle into the partial product
// EXTRA | long fix-up / accumulate cycles
// DONE  | result valid, held until out_ready
module mac_sequencer #(
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] rm,
  input  logic [31:0] rs,
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        n_flag,
  output logic        z_flag
);

  typedef enum logic [1:0] {IDLE, ITER, EXTRA, DONE} state_t;

  state_t      state, state_nxt;
  logic        long_q;
  logic [63:0] mcand_sh;
  logic [31:0] rs_sh;
  logic [63:0] acc_q;
  logic        acc_pend;
  logic [63:0] prod, prod_nxt;
  logic [1:0]  iter_left;
  logic [1:0]  extra_left;
  logic        sign_rem;

  logic        sign_chk;
  logic        fit8, fit16, fit24;
  logic [1:0]  m_minus1;
  logic [1:0]  k;

  assign sign_chk = op[1] | ~op[2];
  assign fit8  = (rs[31:8]  == 24'h0) | (sign_chk & (&rs[31:8]));
  assign fit16 = (rs[31:16] == 16'h0) | (sign_chk & (&rs[31:16]));
  assign fit24 = (rs[31:24] ==  8'h0) | (sign_chk & (&rs[31:24]));
  assign k     = {1'b0, op[2]} + {1'b0, op[0]};

  always_comb begin
    m_minus1 = 2'd3;
    if (EARLY_TERM) begin
      if (fit8)       m_minus1 = 2'd0;
      else if (fit16) m_minus1 = 2'd1;
      else if (fit24) m_minus1 = 2'd2;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = ITER;
      ITER:  if (iter_left == 2'd0) state_nxt = (extra_left != 2'd0) ? EXTRA : DONE;
      EXTRA: if (extra_left == 2'd1) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bytes are added unsigned; when the unconsumed part of rs is all ones the
  // last iteration subtracts the shifted multiplicand to restore the sign.
  always_comb begin
    prod_nxt = prod;
    case (state)
      ITER: begin
        prod_nxt = prod + mcand_sh * {56'h0, rs_sh[7:0]};
        if ((iter_left == 2'd0) && sign_rem)
          prod_nxt = prod_nxt - (mcand_sh << 8);
      end
      EXTRA: if (acc_pend) prod_nxt = prod + acc_q;
      default: prod_nxt = prod;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      long_q     <= 1'b0;
      mcand_sh   <= 64'h0;
      rs_sh      <= 32'h0;
      acc_q      <= 64'h0;
      acc_pend   <= 1'b0;
      prod       <= 64'h0;
      iter_left  <= 2'd0;
      extra_left <= 2'd0;
      sign_rem   <= 1'b0;
      res_hi     <= 32'h0;
      res_lo     <= 32'h0;
      n_flag     <= 1'b0;
      z_flag     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          long_q     <= op[2];
          mcand_sh   <= (op[2] & op[1]) ? {{32{rm[31]}}, rm} : {32'h0, rm};
          rs_sh      <= rs;
          acc_q      <= op[0] ? {(op[2] ? acc_hi : 32'h0), acc_lo} : 64'h0;
          acc_pend   <= op[0];
          prod       <= 64'h0;
          iter_left  <= m_minus1;
          extra_left <= k;
          sign_rem   <= rs[31] & sign_chk;
        end
        ITER: begin
          prod     <= prod_nxt;
          mcand_sh <= mcand_sh << 8;
          rs_sh    <= rs_sh >> 8;
          if (iter_left != 2'd0) iter_left <= iter_left - 2'd1;
        end
        EXTRA: begin
          prod       <= prod_nxt;
          acc_pend   <= 1'b0;
          extra_left <= extra_left - 2'd1;
        end
        default: ;
      endcase

      if ((state != DONE) && (state_nxt == DONE)) begin
        res_lo <= prod_nxt[31:0];
        res_hi <= long_q ? prod_nxt[63:32] : 32'h0;
        n_flag <= long_q ? prod_nxt[63] : prod_nxt[31];
        z_flag <= long_q ? (prod_nxt == 64'h0) : (prod_nxt[31:0] == 32'h0);
      end
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: arithmetic, latency, backpressure and
// mid-operation reset, with an EARLY_TERM=0 instance for fixed-latency checks.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv_et, iv_fx;
  logic [2:0]  op;
  logic [31:0] rm, rs, acc_hi, acc_lo;
  logic        out_ready;

  logic        rdy_et, val_et, n_et, z_et;
  logic [31:0] hi_et, lo_et;
  logic        rdy_fx, val_fx, n_fx, z_fx;
  logic [31:0] hi_fx, lo_fx;

  int tests = 0;
  int fails = 0;
  int sel = 0;

  always #5 clk = ~clk;

  mac_sequencer #(.EARLY_TERM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_et), .in_ready(rdy_et),
    .op(op), .rm(rm), .rs(rs), .acc_hi(acc_hi), .acc_lo(acc_lo),
    .out_valid(val_et), .out_ready(out_ready),
    .res_hi(hi_et), .res_lo(lo_et), .n_flag(n_et), .z_flag(z_et));

  mac_sequencer #(.EARLY_TERM(1'b0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_fx), .in_ready(rdy_fx),
    .op(op), .rm(rm), .rs(rs), .acc_hi(acc_hi), .acc_lo(acc_lo),
    .out_valid(val_fx), .out_ready(out_ready),
    .res_hi(hi_fx), .res_lo(lo_fx), .n_flag(n_fx), .z_flag(z_fx));

  logic        s_rdy, s_val, s_n, s_z;
  logic [31:0] s_hi, s_lo;
  assign s_rdy = (sel == 0) ? rdy_et : rdy_fx;
  assign s_val = (sel == 0) ? val_et : val_fx;
  assign s_n   = (sel == 0) ? n_et   : n_fx;
  assign s_z   = (sel == 0) ? z_et   : z_fx;
  assign s_hi  = (sel == 0) ? hi_et  : hi_fx;
  assign s_lo  = (sel == 0) ? lo_et  : lo_fx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input int which, input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ah, input logic [31:0] al,
                        input int elat, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic en, input logic ez);
    int lat;
    sel = which;
    @(negedge clk);
    op = o; rm = a; rs = b; acc_hi = ah; acc_lo = al;
    if (which == 0) iv_et = 1'b1; else iv_fx = 1'b1;
    check({tag, " in_ready"}, {63'h0, s_rdy}, 64'h1);
    @(posedge clk); #1;
    iv_et = 1'b0; iv_fx = 1'b0;
    lat = 0;
    while (!s_val && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " res_hi"}, {32'h0, s_hi}, {32'h0, ehi});
    check({tag, " res_lo"}, {32'h0, s_lo}, {32'h0, elo});
    check({tag, " n_flag"}, {63'h0, s_n}, {63'h0, en});
    check({tag, " z_flag"}, {63'h0, s_z}, {63'h0, ez});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " released"}, {62'h0, s_val, s_rdy}, 64'h1);
  endtask

  logic [31:0] hold_lo;

  initial begin
    iv_et = 1'b0; iv_fx = 1'b0; out_ready = 1'b0;
    op = 3'b000; rm = 32'h0; rs = 32'h0; acc_hi = 32'h0; acc_lo = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {hi_et, lo_et}, 64'h0);
    check("reset ctl", {59'h0, rdy_et, val_et, n_et, z_et, rdy_fx}, {59'h0, 5'b10001});
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, "mul",   3'b000, 32'd7,        32'd6,        32'h0, 32'h0,        1, 32'h0,        32'd42,       1'b0, 1'b0);
    run_op(0, "mla",   3'b001, 32'hFFFFFFFF, 32'd1,        32'h0, 32'd1,        2, 32'h0,        32'h0,        1'b0, 1'b1);
    run_op(0, "mla_h", 3'b001, 32'd2,        32'd3,        32'hDEAD, 32'd4,     2, 32'h0,        32'd10,       1'b0, 1'b0);
    run_op(0, "mulneg",3'b000, 32'd3,        32'hFFFFFFFF, 32'h0, 32'h0,        1, 32'h0,        32'hFFFFFFFD, 1'b1, 1'b0);
    run_op(0, "umull", 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,        5, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
    run_op(0, "umlal", 3'b101, 32'h00010000, 32'h00010000, 32'd1, 32'hFFFFFFFF, 5, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0);
    run_op(0, "smull", 3'b110, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'h0,        2, 32'h0,        32'd2,        1'b0, 1'b0);
    run_op(0, "smlal", 3'b111, 32'h80000000, 32'h00010000, 32'h0, 32'h0,        5, 32'hFFFF8000, 32'h0,        1'b1, 1'b0);
    run_op(1, "fx_umull", 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,     5, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
    run_op(1, "fx_mul",   3'b000, 32'd7,        32'd6,        32'h0, 32'h0,     4, 32'h0,        32'd42,       1'b0, 1'b0);

    // Backpressure: 0xFFFF * 0x100 (two iterations), held three cycles in DONE.
    sel = 0;
    @(negedge clk);
    op = 3'b000; rm = 32'h0000FFFF; rs = 32'h00000100; iv_et = 1'b1;
    @(posedge clk); #1;
    iv_et = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bp valid", {63'h0, val_et}, 64'h1);
    check("bp res_lo", {32'h0, lo_et}, 64'h00FFFF00);
    hold_lo = lo_et;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op = 3'b100; rm = 32'd9; rs = 32'd9; iv_et = 1'b1;
      @(posedge clk); #1;
      check("bp hold lo", {32'h0, lo_et}, {32'h0, hold_lo});
      check("bp hold ctl", {60'h0, val_et, rdy_et, n_et, z_et}, 64'h8);
    end
    @(negedge clk);
    iv_et = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release", {62'h0, val_et, rdy_et}, 64'h1);
    repeat (2) @(posedge clk);
    #1;
    check("bp no accept", {62'h0, val_et, rdy_et}, 64'h1);

    // Reset in the middle of a four-iteration UMULL.
    @(negedge clk);
    op = 3'b100; rm = 32'd5; rs = 32'hFFFFFFFF; iv_et = 1'b1;
    @(posedge clk); #1;
    iv_et = 1'b0;
    check("mid busy", {63'h0, rdy_et}, 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst res", {hi_et, lo_et}, 64'h0);
    check("rst ctl", {60'h0, rdy_et, val_et, n_et, z_et}, 64'h8);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst discarded", {62'h0, val_et, rdy_et}, 64'h1);
    run_op(0, "mul_after_rst", 3'b000, 32'd3, 32'd5, 32'h0, 32'h0, 1, 32'h0, 32'd15, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Multi-cycle multiply/multiply-accumulate controller for the ARM7TDMI execute stage.
- Accepts MUL/MLA/UMULL/UMLAL/SMULL/SMLAL commands over a valid/ready handshake and iterates 8 multiplier bits per cycle, with ARM7-style early termination.
- Returns a 32- or 64-bit result with N/Z flags over a second valid/ready handshake.
- Sits between decode/register-read and writeback; stalls the pipeline via in_ready.

Parameters:
- EARLY_TERM, 1: 1 = iteration count depends on rs (early termination); 0 = always 4 iterations.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  command valid.
- in_ready  output  1  controller idle, command accepted when in_valid & in_ready.
- op  input  3  bit2 = long (64-bit), bit1 = signed (long only; ignored when bit2=0), bit0 = accumulate.
- rm  input  32  multiplicand.
- rs  input  32  multiplier.
- acc_hi  input  32  accumulator high word (long accumulate only).
- acc_lo  input  32  accumulator low word.
- out_valid  output  1  result valid, held until out_ready.
- out_ready  input  1  consumer accepts result.
- res_hi  output  32  result high word; 0 for short ops.
- res_lo  output  32  result low word.
- n_flag  output  1  result sign: bit63 for long ops, bit31 for short ops.
- z_flag  output  1  result == 0, over 64 bits for long ops, 32 bits for short ops.

Behaviour:
- Reset (rst_n low at an edge), from any state including mid-operation:
  - state = IDLE; in_ready = 1.
  - out_valid, res_hi, res_lo, n_flag, z_flag = 0.
  - Any in-flight operation is discarded.
- States: IDLE, ITER, EXTRA, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at an edge: latch op, rm, rs, acc_hi, acc_lo; compute m and k; go to ITER.
- Iteration count m (EARLY_TERM = 1), with sign-check = op[1] | ~op[2]:
  - m = 1 if rs[31:8] is all 0s, or all 1s when sign-check is set.
  - m = 2 if the same test passes on rs[31:16].
  - m = 3 if it passes on rs[31:24].
  - m = 4 otherwise.
  - EARLY_TERM = 0 forces m = 4.
- Extra cycles: k = op[2] + op[0] (0..2).
- ITER:
  - Stays exactly m cycles, each consuming 8 rs bits LSB-first into a partial-product accumulator.
  - Go to EXTRA if k > 0, else DONE.
- EXTRA: stays exactly k cycles (long high-word fix-up, accumulate add), then DONE.
- DONE:
  - out_valid = 1.
  - res_hi, res_lo, n_flag, z_flag are stable and must not change while out_valid & ~out_ready.
  - On out_ready at an edge: out_valid falls, go to IDLE; in_ready = 1 in the following cycle.
- Latency: out_valid first high exactly m+k cycles after the accepting edge. Commands are never accepted while not IDLE (in_valid ignored).
- Arithmetic:
  - Short ops: res_lo = (rm*rs + (op[0] ? acc_lo : 0)) mod 2^32, res_hi = 0. Signedness is irrelevant.
  - Long ops: 64-bit rm*rs, signed if op[1] else unsigned, plus {acc_hi,acc_lo} if op[0], mod 2^64.
  - Wrap-around is silent: no saturation, no C/V flags produced.
- in_ready is low in ITER, EXTRA and DONE.
- No combinational path from in_valid to out_valid or from out_ready to in_ready.

Test Plan:
- MUL (op=000), rm=7, rs=6 -> out_valid 1 cycle after accept; res_lo=42, res_hi=0, n=0, z=0.
- MLA (op=001), rm=0xFFFFFFFF, rs=1, acc_lo=1 -> latency 2; res_lo=0, z=1, n=0.
- UMULL (op=100), rm=rs=0xFFFFFFFF -> latency 5; res_hi=0xFFFFFFFE, res_lo=0x00000001, n=1, z=0.
  - With EARLY_TERM=0, latency is still 5; MUL rm=7, rs=6 takes 4 cycles.
- SMULL (op=110), rm=0xFFFFFFFF, rs=0xFFFFFFFE -> latency 2 (m=1); res_hi=0, res_lo=2, n=0.
- SMLAL (op=111), rm=0x80000000, rs=0x00010000, acc=0 -> latency 5 (m=3, k=2); res_hi=0xFFFF8000, res_lo=0, n=1.
- Backpressure/reset:
  - Hold out_ready low 3 cycles in DONE -> outputs stable, in_valid pulses ignored.
  - Next, rst_n low during ITER -> after that edge all outputs 0 and in_ready=1; a new MUL 3*5 then returns 15 normally.
